prog_loader: RTL

Byte-serial program loader for the 16-bit RISC CPU. It receives a framed byte stream from the board's serial receiver, assembles big-endian 16-bit words and writes them into unified instruction/data memory through the memory write port. It is the writer that fills the memory the control unit later fetches from and loads from. While loading, it holds the CPU in reset, and it releases the CPU after a frame completes with a valid checksum.

---
 rtl/prog_loader_pkg.sv | 27 ++
 rtl/prog_loader.sv | 140 ++++++++++++++
 2 files changed

// File: rtl/prog_loader_pkg.sv
// Shared definitions for the byte-serial program loader.
// The state encoding mirrors the frame field order on the wire:
//   SYNC, ADR_H, ADR_L, CNT_H, CNT_L, {DAT_H, DAT_L} x CNT, CSUM.
// IDLE waits for SYNC; DONE and ERROR record the last frame outcome.
package prog_loader_pkg;

   // Loader states. The numeric values appear on the status LEDs.
   typedef enum logic [3:0] {
      ST_IDLE  = 4'd0,  // waiting for SYNC
      ST_ADRH  = 4'd1,  // expecting ADR_H
      ST_ADRL  = 4'd2,  // expecting ADR_L
      ST_CNTH  = 4'd3,  // expecting CNT_H
      ST_CNTL  = 4'd4,  // expecting CNT_L
      ST_DATH  = 4'd5,  // expecting DAT_H
      ST_DATL  = 4'd6,  // expecting DAT_L
      ST_CSUM  = 4'd7,  // expecting CSUM
      ST_DONE  = 4'd8,  // last frame good
      ST_ERROR = 4'd9   // last frame bad
   } state_t;

   // Frame start marker.
   localparam logic [7:0]  SYNC_BYTE_DEF   = 8'hA5;

   // Inter-byte timeout in clocks (used only with the timeout feature).
   localparam logic [15:0] TIMEOUT_CYC_DEF = 16'd50000;

endpackage

// File: rtl/prog_loader.sv
// Byte-serial program loader: parses SYNC/address/count/data/checksum
// frames, writes big-endian 16-bit words to memory, and holds the CPU in
// reset until a frame completes with a matching checksum.
// Optional feature macro: PROG_LOADER_TIMEOUT_EN (inter-byte timeout that
// forces ERROR when a frame stalls between ADRH and CSUM).
//
// Handshake: rx_valid is a one-cycle strobe qualifying rx_data; there is
// no back-pressure, and strobes arrive at least two cycles apart, so the
// write pulse issued after DAT_L never overlaps the next byte capture.
module prog_loader
  import prog_loader_pkg::*;
#(
  parameter logic [7:0]  SYNC_BYTE   = SYNC_BYTE_DEF,
  parameter logic [15:0] TIMEOUT_CYC = TIMEOUT_CYC_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic [15:0] mem_adr,
  output logic [15:0] mem_dout,
  output logic        mem_we,
  output logic        cpu_hold,
  output logic        done,
  output logic        err,
  output logic [7:0]  status
);

  state_t      state;
  logic [15:0] ptr;
  logic [15:0] cnt;
  logic [7:0]  sum;
  logic [7:0]  hi_byte;
`ifdef PROG_LOADER_TIMEOUT_EN
  logic [15:0] idle_cnt;
`endif

  assign status = {cpu_hold, err, done, 1'b0, state};

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= ST_IDLE;
      ptr      <= 16'h0000;
      cnt      <= 16'h0000;
      sum      <= 8'h00;
      hi_byte  <= 8'h00;
      mem_adr  <= 16'h0000;
      mem_dout <= 16'h0000;
      mem_we   <= 1'b0;
      cpu_hold <= 1'b1;
      done     <= 1'b0;
      err      <= 1'b0;
`ifdef PROG_LOADER_TIMEOUT_EN
      idle_cnt <= 16'h0000;
`endif
    end else begin
      mem_we <= 1'b0;

      if (rx_valid) begin
        case (state)
          ST_IDLE, ST_DONE, ST_ERROR: begin
            if (rx_data == SYNC_BYTE) begin
              state    <= ST_ADRH;
              done     <= 1'b0;
              err      <= 1'b0;
              sum      <= 8'h00;
              cpu_hold <= 1'b1;
            end
          end
          ST_ADRH: begin
            ptr[15:8] <= rx_data;
            sum       <= sum + rx_data;
            state     <= ST_ADRL;
          end
          ST_ADRL: begin
            ptr[7:0] <= rx_data;
            sum      <= sum + rx_data;
            state    <= ST_CNTH;
          end
          ST_CNTH: begin
            cnt[15:8] <= rx_data;
            sum       <= sum + rx_data;
            state     <= ST_CNTL;
          end
          ST_CNTL: begin
            cnt[7:0] <= rx_data;
            sum      <= sum + rx_data;
            if ({cnt[15:8], rx_data} == 16'h0000) state <= ST_CSUM;
            else                                  state <= ST_DATH;
          end
          ST_DATH: begin
            hi_byte <= rx_data;
            sum     <= sum + rx_data;
            state   <= ST_DATL;
          end
          ST_DATL: begin
            mem_dout <= {hi_byte, rx_data};
            mem_adr  <= ptr;
            mem_we   <= 1'b1;
            ptr      <= ptr + 16'd1;
            cnt      <= cnt - 16'd1;
            sum      <= sum + rx_data;
            if (cnt == 16'd1) state <= ST_CSUM;
            else              state <= ST_DATH;
          end
          ST_CSUM: begin
            if (rx_data == sum) begin
              state    <= ST_DONE;
              done     <= 1'b1;
              cpu_hold <= 1'b0;
            end else begin
              state    <= ST_ERROR;
              err      <= 1'b1;
              cpu_hold <= 1'b1;
            end
          end
          default: state <= ST_IDLE;
        endcase
      end

`ifdef PROG_LOADER_TIMEOUT_EN
      if (state >= ST_ADRH && state <= ST_CSUM) begin
        if (rx_valid) begin
          idle_cnt <= 16'h0000;
        end else if (idle_cnt == TIMEOUT_CYC - 16'd1) begin
          idle_cnt <= 16'h0000;
          state    <= ST_ERROR;
          err      <= 1'b1;
          cpu_hold <= 1'b1;
        end else begin
          idle_cnt <= idle_cnt + 16'd1;
        end
      end else begin
        idle_cnt <= 16'h0000;
      end
`endif
    end
  end

endmodule
